// File: rtl/cache_mem_pkg.sv
// Shared types and sizing for the cache-line / main-memory burst adaptor.
package cache_mem_pkg;

    localparam int unsigned LINE_WIDTH  = 256;
    localparam int unsigned BURST_WIDTH = 64;
    localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int unsigned CNT_WIDTH   = $clog2(BEATS);

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [BURST_WIDTH-1:0] beat_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [CNT_WIDTH-1:0]   cnt_t;

    localparam cnt_t  LAST_BEAT = cnt_t'(BEATS - 1);
    localparam addr_t LINE_MASK = {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit cache-line request into a 4 x 64-bit burst on main memory,
// reassembling read beats and serialising write beats.
module cacheline_adaptor
    import cache_mem_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  pmem_read,
    input  logic  pmem_write,
    input  addr_t pmem_address,
    input  line_t pmem_wdata,
    output line_t pmem_rdata,
    output logic  pmem_resp,
    output addr_t burst_address,
    output logic  burst_read,
    output logic  burst_write,
    output beat_t burst_wdata,
    input  beat_t burst_rdata,
    input  logic  burst_resp
);

    adaptor_state_t state_q, state_d;
    cnt_t           cnt_q, cnt_d;
    addr_t          addr_q, addr_d;
    line_t          wline_q, wline_d;
    line_t          rdata_q, rdata_d;
    // Only the first BEATS-1 read beats need staging; the last one goes straight to rdata.
    logic [LINE_WIDTH-BURST_WIDTH-1:0] rline_q, rline_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    addr_d  = pmem_address & LINE_MASK;
                    wline_d = pmem_wdata;
                    state_d = WR_BURST;
                end else if (pmem_read) begin
                    addr_d  = pmem_address & LINE_MASK;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = {burst_rdata, rline_q};
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        rline_d[BURST_WIDTH*cnt_q +: BURST_WIDTH] = burst_rdata;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // Requests are ignored here: the requester still holds the finished one.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        burst_wdata = wline_q[BURST_WIDTH*cnt_q +: BURST_WIDTH];
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = (state_q == DONE);
    assign burst_address = addr_q;
    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);

endmodule
